fwd_hazard_unit: RTL and testbench

Parametrised operand-forwarding and load-use interlock unit for the pipelined MIPS core, successor to the two-operand EX/MEM forwarder. Compares up to NSRC decode-stage source registers plus HI/LO reads against NSTAGE downstream producer stages, returns the youngest ready value per operand, and holds the decode stage through a multi-cycle stall FSM until every unresolved producer is ready. Sits beside ID; outputs feed the ID operand muxes and the pipeline-freeze logic.

---
 rtl/fwd_hazard_unit.sv | 149 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use interlock for the ID stage of the MIPS pipeline.
// Latency: registered on the falling clk edge, so outputs are valid for the next rising edge.
// Backpressure: stall holds decode until every matched producer is ready; flush aborts the slot.
module fwd_hazard_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int NSRC      = 2,
    parameter int NSTAGE    = 3,
    parameter int MAX_STALL = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NSRC-1:0]          src_rena,
    input  logic [NSRC*REG_W-1:0]    src_addr,
    input  logic                     hi_req,
    input  logic                     lo_req,
    input  logic [NSTAGE-1:0]        st_wena,
    input  logic [NSTAGE*REG_W-1:0]  st_rdc,
    input  logic [NSTAGE-1:0]        st_ready,
    input  logic [NSTAGE*DATA_W-1:0] st_data,
    input  logic [NSTAGE-1:0]        st_hi_wena,
    input  logic [NSTAGE-1:0]        st_lo_wena,
    input  logic [NSTAGE*DATA_W-1:0] st_hi_data,
    input  logic [NSTAGE*DATA_W-1:0] st_lo_data,
    output logic                     stall,
    output logic [NSRC-1:0]          fwd_valid,
    output logic [NSRC*DATA_W-1:0]   fwd_data,
    output logic                     hi_fwd,
    output logic                     lo_fwd,
    output logic [DATA_W-1:0]        hi_data,
    output logic [DATA_W-1:0]        lo_data,
    output logic [7:0]               stall_cnt,
    output logic                     timeout_err
);

    localparam logic       S_IDLE  = 1'b0;
    localparam logic       S_STALL = 1'b1;
    localparam logic [7:0] MAX_C   = 8'(MAX_STALL);

    logic                   state;
    logic [NSRC-1:0]        pending;
    logic [NSRC-1:0]        hit;
    logic [NSRC-1:0]        rdy;
    logic [NSRC-1:0]        unres;
    logic [NSRC-1:0]        still;
    logic [NSRC*DATA_W-1:0] mdat;
    logic                   hi_hit;
    logic                   lo_hit;
    logic [DATA_W-1:0]      hi_mdat;
    logic [DATA_W-1:0]      lo_mdat;
    logic [7:0]             cnt_inc;

    // Scan oldest to youngest so the youngest matching stage wins, ready or not.
    always_comb begin
        hit     = '0;
        rdy     = '0;
        mdat    = '0;
        hi_hit  = 1'b0;
        lo_hit  = 1'b0;
        hi_mdat = '0;
        lo_mdat = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if (src_rena[i] && !hi_req && !lo_req &&
                    src_addr[i*REG_W +: REG_W] != '0 && st_wena[s] &&
                    st_rdc[s*REG_W +: REG_W] == src_addr[i*REG_W +: REG_W]) begin
                    hit[i] = 1'b1;
                    rdy[i] = st_ready[s];
                    mdat[i*DATA_W +: DATA_W] = st_data[s*DATA_W +: DATA_W];
                end
            end
        end
        for (int s = NSTAGE - 1; s >= 0; s--) begin
            if (hi_req && st_hi_wena[s]) begin
                hi_hit  = 1'b1;
                hi_mdat = st_hi_data[s*DATA_W +: DATA_W];
            end
            if (lo_req && st_lo_wena[s]) begin
                lo_hit  = 1'b1;
                lo_mdat = st_lo_data[s*DATA_W +: DATA_W];
            end
        end
    end

    assign unres   = hit & ~rdy;
    assign still   = pending & unres;
    assign cnt_inc = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pending     <= '0;
            stall       <= 1'b0;
            fwd_valid   <= '0;
            fwd_data    <= '0;
            hi_fwd      <= 1'b0;
            lo_fwd      <= 1'b0;
            hi_data     <= '0;
            lo_data     <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            pending   <= '0;
            stall     <= 1'b0;
            fwd_valid <= '0;
            hi_fwd    <= 1'b0;
            lo_fwd    <= 1'b0;
        end else begin
            hi_fwd  <= hi_hit;
            lo_fwd  <= lo_hit;
            hi_data <= hi_mdat;
            lo_data <= lo_mdat;
            if (state == S_IDLE) begin
                fwd_valid <= hit & rdy;
                for (int i = 0; i < NSRC; i++) begin
                    if (hit[i] && rdy[i]) fwd_data[i*DATA_W +: DATA_W] <= mdat[i*DATA_W +: DATA_W];
                end
                pending <= unres;
                if (|unres) begin
                    stall     <= 1'b1;
                    stall_cnt <= 8'd1;
                    state     <= S_STALL;
                    if (MAX_C <= 8'd1) timeout_err <= 1'b1;
                end else begin
                    stall <= 1'b0;
                end
            end else begin
                // Operands resolved on an earlier edge keep their latched value.
                for (int i = 0; i < NSRC; i++) begin
                    if (pending[i] && !unres[i]) begin
                        fwd_valid[i] <= hit[i];
                        if (hit[i]) fwd_data[i*DATA_W +: DATA_W] <= mdat[i*DATA_W +: DATA_W];
                    end
                end
                pending <= still;
                if (|still) begin
                    stall_cnt <= cnt_inc;
                    if (cnt_inc >= MAX_C) timeout_err <= 1'b1;
                end else begin
                    stall <= 1'b0;
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; inputs change and outputs are checked 1 time unit after each falling edge.
module tb_fwd_hazard_unit;

    logic        clk = 1'b1;
    logic        rst;
    logic        flush;
    logic [1:0]  src_rena;
    logic [9:0]  src_addr;
    logic        hi_req, lo_req;
    logic [2:0]  st_wena, st_ready, st_hi_wena, st_lo_wena;
    logic [14:0] st_rdc;
    logic [95:0] st_data, st_hi_data, st_lo_data;
    logic        stall, hi_fwd, lo_fwd, timeout_err;
    logic [1:0]  fwd_valid;
    logic [63:0] fwd_data;
    logic [31:0] hi_data, lo_data;
    logic [7:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit #(.DATA_W(32), .REG_W(5), .NSRC(2), .NSTAGE(3), .MAX_STALL(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_rena(src_rena), .src_addr(src_addr), .hi_req(hi_req), .lo_req(lo_req),
        .st_wena(st_wena), .st_rdc(st_rdc), .st_ready(st_ready), .st_data(st_data),
        .st_hi_wena(st_hi_wena), .st_lo_wena(st_lo_wena),
        .st_hi_data(st_hi_data), .st_lo_data(st_lo_data),
        .stall(stall), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .hi_fwd(hi_fwd), .lo_fwd(lo_fwd), .hi_data(hi_data), .lo_data(lo_data),
        .stall_cnt(stall_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        flush = 0; src_rena = '0; src_addr = '0; hi_req = 0; lo_req = 0;
        st_wena = '0; st_rdc = '0; st_ready = '0; st_data = '0;
        st_hi_wena = '0; st_lo_wena = '0; st_hi_data = '0; st_lo_data = '0;
    endtask

    task automatic set_st(input int s, input logic [4:0] rd, input logic r, input logic [31:0] d);
        st_wena[s]          = 1'b1;
        st_rdc[s*5 +: 5]    = rd;
        st_ready[s]         = r;
        st_data[s*32 +: 32] = d;
    endtask

    task automatic set_src(input int i, input logic [4:0] rs);
        src_rena[i]        = 1'b1;
        src_addr[i*5 +: 5] = rs;
    endtask

    initial begin
        rst = 0;
        clr();
        tick(); tick();
        chk("rst_stall", stall, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1;

        // Youngest writer wins over an older one.
        set_st(0, 5'd8, 1, 32'h11); set_st(1, 5'd8, 1, 32'h22); set_src(0, 5'd8);
        tick();
        chk("ex_prio_valid", fwd_valid, 2'b01);
        chk("ex_prio_data", fwd_data[31:0], 32'h11);
        chk("ex_prio_stall", stall, 0);

        clr(); set_st(0, 5'd0, 1, 32'hFF); set_src(0, 5'd0);
        tick();
        chk("r0_valid", fwd_valid, 2'b00);
        chk("r0_stall", stall, 0);

        // Load-use: EX load not ready, then MEM supplies the value.
        clr(); set_st(0, 5'd9, 0, 32'hDEAD); set_src(1, 5'd9);
        tick();
        chk("ld_stall", stall, 1);
        chk("ld_cnt", stall_cnt, 1);
        chk("ld_valid_wait", fwd_valid, 2'b00);
        clr(); set_st(1, 5'd9, 1, 32'hABCD); set_src(1, 5'd9);
        tick();
        chk("ld_release", stall, 0);
        chk("ld_cnt_hold", stall_cnt, 1);
        chk("ld_valid", fwd_valid, 2'b10);
        chk("ld_data", fwd_data[63:32], 32'hABCD);

        // Op0 blocked by unready EX (older WB copy must not be used), op1 resolves at once.
        clr(); set_st(0, 5'd3, 0, 32'h0); set_st(1, 5'd4, 1, 32'h44); set_st(2, 5'd3, 1, 32'h99);
        set_src(0, 5'd3); set_src(1, 5'd4);
        tick();
        chk("two_stall", stall, 1);
        chk("two_valid_part", fwd_valid, 2'b10);
        chk("two_data1", fwd_data[63:32], 32'h44);
        clr(); set_st(1, 5'd3, 1, 32'h33); set_st(2, 5'd4, 1, 32'h44);
        set_src(0, 5'd3); set_src(1, 5'd4);
        tick();
        chk("two_release", stall, 0);
        chk("two_valid", fwd_valid, 2'b11);
        chk("two_data0", fwd_data[31:0], 32'h33);

        // MFHI ignores GPR hazards; MEM HI is the youngest writer.
        clr(); hi_req = 1; set_src(0, 5'd5); set_st(0, 5'd5, 0, 32'h0);
        st_hi_wena = 3'b110; st_hi_data[63:32] = 32'h1234; st_hi_data[95:64] = 32'h5678;
        tick();
        chk("hi_fwd", hi_fwd, 1);
        chk("hi_data", hi_data, 32'h1234);
        chk("hi_no_stall", stall, 0);
        chk("hi_gpr_ignored", fwd_valid, 2'b00);
        clr(); lo_req = 1;
        tick();
        chk("lo_none", lo_fwd, 0);
        chk("hi_cleared", hi_fwd, 0);

        // Producer held unready: timeout at MAX_STALL, survives flush.
        clr(); set_st(0, 5'd7, 0, 32'h0); set_src(0, 5'd7);
        for (int k = 0; k < 6; k++) tick();
        chk("to_cnt6", stall_cnt, 6);
        chk("to_not_yet", timeout_err, 0);
        tick();
        chk("to_cnt7", stall_cnt, 7);
        chk("to_set", timeout_err, 1);
        chk("to_stall", stall, 1);
        flush = 1;
        tick();
        chk("fl_stall", stall, 0);
        chk("fl_timeout_sticky", timeout_err, 1);
        chk("fl_valid", fwd_valid, 2'b00);

        // Asynchronous reset in the middle of a stall.
        clr(); set_st(0, 5'd7, 0, 32'h0); set_src(0, 5'd7);
        tick();
        chk("mid_stall", stall, 1);
        #2 rst = 0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_cnt", stall_cnt, 0);
        chk("arst_timeout", timeout_err, 0);
        chk("arst_data", fwd_data, 64'h0);
        clr();
        #2 rst = 1;
        tick();
        chk("post_rst_stall", stall, 0);
        chk("post_rst_cnt", stall_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
